// File: rtl/cluster_boot_regs.sv
// cluster_boot_regs: AXI4-Lite responder holding the cluster boot SCRATCH
// register and the per-core cluster-local interrupt pending bits (mxip).
// One transaction is outstanding at a time; a write wins over a read that
// arrives in the same cycle.
module cluster_boot_regs #(
    parameter int unsigned AddrWidth     = 48,
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned NrCores       = 9,
    parameter logic [63:0] ScratchRstVal = 64'h0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [AddrWidth-1:0]   base_addr_i,
    input  logic                   aw_valid_i,
    output logic                   aw_ready_o,
    input  logic [AddrWidth-1:0]   aw_addr_i,
    input  logic                   w_valid_i,
    output logic                   w_ready_o,
    input  logic [DataWidth-1:0]   w_data_i,
    input  logic [DataWidth/8-1:0] w_strb_i,
    output logic                   b_valid_o,
    input  logic                   b_ready_i,
    output logic [1:0]             b_resp_o,
    input  logic                   ar_valid_i,
    output logic                   ar_ready_o,
    input  logic [AddrWidth-1:0]   ar_addr_i,
    output logic                   r_valid_o,
    input  logic                   r_ready_i,
    output logic [DataWidth-1:0]   r_data_o,
    output logic [1:0]             r_resp_o,
    input  logic [NrCores-1:0]     mxip_clr_i,
    output logic [NrCores-1:0]     mxip_o,
    output logic [DataWidth-1:0]   scratch_o
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] IDX_SCRATCH = 2'd0;
    localparam logic [1:0] IDX_SET     = 2'd1;
    localparam logic [1:0] IDX_CLR     = 2'd2;
    localparam logic [1:0] IDX_CLINT   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRESP = 2'd1,
        ST_RRESP = 2'd2
    } state_e;

    // Expand byte strobes into a per-bit write mask.
    function automatic logic [DataWidth-1:0] strb_to_mask(input logic [DataWidth/8-1:0] strb);
        logic [DataWidth-1:0] mask;
        for (int i = 0; i < DataWidth/8; i++) begin
            mask[i*8 +: 8] = {8{strb[i]}};
        end
        return mask;
    endfunction

    state_e                 state_r, state_s;
    logic [AddrWidth-1:0]   wr_off_s, rd_off_s;
    logic                   wr_mapped_s, rd_mapped_s;
    logic [1:0]             wr_idx_s, rd_idx_s;
    logic                   wr_req_s, write_fire_s, read_fire_s, wr_ok_s;
    logic [DataWidth-1:0]   wmask_s;
    logic [NrCores-1:0]     set_s, clr_w_s, mxip_s, mxip_r;
    logic [DataWidth-1:0]   scratch_s, scratch_r;
    logic [DataWidth-1:0]   rd_data_s, r_data_r;
    logic [1:0]             rd_resp_s, r_resp_r, b_resp_r;

    // Address decode: offsets relative to base; wrap-around below base is unmapped.
    always_comb begin
        wr_off_s    = aw_addr_i - base_addr_i;
        rd_off_s    = ar_addr_i - base_addr_i;
        wr_mapped_s = (wr_off_s < AddrWidth'(32'h20));
        rd_mapped_s = (rd_off_s < AddrWidth'(32'h20));
        wr_idx_s    = wr_off_s[4:3];
        rd_idx_s    = rd_off_s[4:3];
        wr_ok_s     = wr_mapped_s & (wr_idx_s != IDX_CLINT);
    end

    // Handshake: AW and W accepted only together, writes take priority over reads.
    always_comb begin
        wr_req_s     = aw_valid_i & w_valid_i;
        write_fire_s = (state_r == ST_IDLE) & wr_req_s;
        read_fire_s  = (state_r == ST_IDLE) & ar_valid_i & ~wr_req_s;
    end

    assign aw_ready_o = write_fire_s;
    assign w_ready_o  = write_fire_s;
    assign ar_ready_o = read_fire_s;
    assign b_valid_o  = (state_r == ST_WRESP);
    assign r_valid_o  = (state_r == ST_RRESP);
    assign b_resp_o   = b_resp_r;
    assign r_data_o   = r_data_r;
    assign r_resp_o   = r_resp_r;
    assign mxip_o     = mxip_r;
    assign scratch_o  = scratch_r;

    // Register write effects: strobed SCRATCH update and mxip set/clear merge.
    always_comb begin
        wmask_s   = strb_to_mask(w_strb_i);
        scratch_s = scratch_r;
        set_s     = {NrCores{1'b0}};
        clr_w_s   = {NrCores{1'b0}};
        if (write_fire_s && wr_mapped_s) begin
            case (wr_idx_s)
                IDX_SCRATCH: scratch_s = (scratch_r & ~wmask_s) | (w_data_i & wmask_s);
                IDX_SET:     set_s     = w_data_i[NrCores-1:0] & wmask_s[NrCores-1:0];
                IDX_CLR:     clr_w_s   = w_data_i[NrCores-1:0] & wmask_s[NrCores-1:0];
                default:     scratch_s = scratch_r;
            endcase
        end else begin
            scratch_s = scratch_r;
        end
        // A bus set beats a core-side clear in the same cycle.
        mxip_s = (mxip_r | set_s) & ~(clr_w_s | (mxip_clr_i & ~set_s));
    end

    // Read mux: sampled at acceptance, so it reflects pre-update state.
    always_comb begin
        rd_data_s = {DataWidth{1'b0}};
        rd_resp_s = RESP_OKAY;
        if (!rd_mapped_s) begin
            rd_resp_s = RESP_SLVERR;
        end else begin
            case (rd_idx_s)
                IDX_SCRATCH: rd_data_s = scratch_r;
                IDX_CLINT:   rd_data_s = DataWidth'(mxip_r);
                default:     rd_data_s = {DataWidth{1'b0}};
            endcase
        end
    end

    // Next-state logic for the single-outstanding-transaction FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (write_fire_s) begin
                    state_s = ST_WRESP;
                end else if (read_fire_s) begin
                    state_s = ST_RRESP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WRESP: begin
                if (b_ready_i) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WRESP;
                end
            end
            ST_RRESP: begin
                if (r_ready_i) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RRESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Response payload captured at acceptance and held while valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            b_resp_r <= RESP_OKAY;
            r_resp_r <= RESP_OKAY;
            r_data_r <= {DataWidth{1'b0}};
        end else begin
            if (write_fire_s) begin
                b_resp_r <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
            end
            if (read_fire_s) begin
                r_resp_r <= rd_resp_s;
                r_data_r <= rd_data_s;
            end
        end
    end

    // Architectural registers: SCRATCH and interrupt pending bits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scratch_r <= ScratchRstVal;
            mxip_r    <= {NrCores{1'b0}};
        end else begin
            scratch_r <= scratch_s;
            mxip_r    <= mxip_s;
        end
    end

endmodule

// File: tb/tb_cluster_boot_regs.sv
// Directed testbench for cluster_boot_regs (NrCores = 9).
module tb_cluster_boot_regs;

    localparam logic [63:0] RST_SCRATCH = 64'h0123_4567_89AB_CDEF;
    localparam logic [47:0] BASE        = 48'h0000_4000_0000;
    localparam logic [1:0]  OKAY        = 2'b00;
    localparam logic [1:0]  SLVERR      = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [47:0] base_addr = BASE;
    logic        aw_valid = 1'b0, aw_ready;
    logic [47:0] aw_addr = 48'h0;
    logic        w_valid = 1'b0, w_ready;
    logic [63:0] w_data = 64'h0;
    logic [7:0]  w_strb = 8'h0;
    logic        b_valid, b_ready = 1'b0;
    logic [1:0]  b_resp;
    logic        ar_valid = 1'b0, ar_ready;
    logic [47:0] ar_addr = 48'h0;
    logic        r_valid, r_ready = 1'b0;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic [8:0]  mxip_clr = 9'h0;
    logic [8:0]  mxip;
    logic [63:0] scratch;

    int checks = 0;
    int errors = 0;

    cluster_boot_regs #(
        .AddrWidth(48), .DataWidth(64), .NrCores(9), .ScratchRstVal(RST_SCRATCH)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .base_addr_i(base_addr),
        .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_addr_i(aw_addr),
        .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data), .w_strb_i(w_strb),
        .b_valid_o(b_valid), .b_ready_i(b_ready), .b_resp_o(b_resp),
        .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_addr_i(ar_addr),
        .r_valid_o(r_valid), .r_ready_i(r_ready), .r_data_o(r_data), .r_resp_o(r_resp),
        .mxip_clr_i(mxip_clr), .mxip_o(mxip), .scratch_o(scratch)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Single write with immediate B acceptance; caller is at posedge+1.
    task automatic axi_write(input string tag, input logic [47:0] off, input logic [63:0] data,
                             input logic [7:0] strb, input logic [1:0] exp_resp);
        aw_addr = BASE + off; w_data = data; w_strb = strb;
        aw_valid = 1'b1; w_valid = 1'b1;
        #1;
        check({tag, "_awready"}, 64'(aw_ready), 64'd1);
        check({tag, "_wready"}, 64'(w_ready), 64'd1);
        @(posedge clk); #1;
        aw_valid = 1'b0; w_valid = 1'b0;
        check({tag, "_bvalid"}, 64'(b_valid), 64'd1);
        check({tag, "_bresp"}, 64'(b_resp), 64'(exp_resp));
        b_ready = 1'b1;
        @(posedge clk); #1;
        b_ready = 1'b0;
        check({tag, "_bdone"}, 64'(b_valid), 64'd0);
    endtask

    // Single read with immediate R acceptance; caller is at posedge+1.
    task automatic axi_read(input string tag, input logic [47:0] off,
                            input logic [63:0] exp_data, input logic [1:0] exp_resp);
        ar_addr = BASE + off; ar_valid = 1'b1;
        #1;
        check({tag, "_arready"}, 64'(ar_ready), 64'd1);
        @(posedge clk); #1;
        ar_valid = 1'b0;
        check({tag, "_rvalid"}, 64'(r_valid), 64'd1);
        check({tag, "_rdata"}, r_data, exp_data);
        check({tag, "_rresp"}, 64'(r_resp), 64'(exp_resp));
        r_ready = 1'b1;
        @(posedge clk); #1;
        r_ready = 1'b0;
        check({tag, "_rdone"}, 64'(r_valid), 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_awready", 64'(aw_ready), 64'd0);
        check("rst_arready", 64'(ar_ready), 64'd0);
        check("rst_bvalid", 64'(b_valid), 64'd0);
        check("rst_rvalid", 64'(r_valid), 64'd0);
        check("rst_bresp", 64'(b_resp), 64'd0);
        check("rst_rresp", 64'(r_resp), 64'd0);
        check("rst_rdata", r_data, 64'd0);
        check("rst_mxip", 64'(mxip), 64'd0);
        check("rst_scratch", scratch, RST_SCRATCH);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // SCRATCH full and partial writes
        axi_write("scr_full", 48'h00, 64'h0000_0000_8000_0000, 8'hFF, OKAY);
        check("scr_full_val", scratch, 64'h0000_0000_8000_0000);
        axi_read("scr_rd", 48'h00, 64'h0000_0000_8000_0000, OKAY);
        axi_write("scr_pre", 48'h00, 64'hAAAA_AAAA_0000_0000, 8'hFF, OKAY);
        axi_write("scr_part", 48'h00, 64'hFFFF_FFFF_1234_5678, 8'h0F, OKAY);
        check("scr_part_val", scratch, 64'hAAAA_AAAA_1234_5678);

        // CLINT set / clear / read
        axi_write("set_all", 48'h08, 64'h1FF, 8'hFF, OKAY);
        check("set_all_mxip", 64'(mxip), 64'h1FF);
        axi_write("clr3", 48'h10, 64'h003, 8'hFF, OKAY);
        check("clr3_mxip", 64'(mxip), 64'h1FC);
        axi_read("clint_rd", 48'h18, 64'h1FC, OKAY);
        axi_read("set_rd", 48'h08, 64'h0, OKAY);
        axi_read("clr_rd", 48'h10, 64'h0, OKAY);
        axi_write("clr_all", 48'h10, 64'h1FF, 8'hFF, OKAY);
        check("clr_all_mxip", 64'(mxip), 64'h0);
        axi_write("set_strb", 48'h08, 64'h1FF, 8'h02, OKAY);
        check("set_strb_mxip", 64'(mxip), 64'h100);
        axi_write("set_high", 48'h08, 64'hFFFF_FFFF_FFFF_FE00, 8'hFF, OKAY);
        check("set_high_mxip", 64'(mxip), 64'h100);

        // Bus set beats same-cycle core clear; held clear then wins
        aw_addr = BASE + 48'h08; w_data = 64'h004; w_strb = 8'hFF;
        aw_valid = 1'b1; w_valid = 1'b1; mxip_clr = 9'h004;
        @(posedge clk); #1;
        aw_valid = 1'b0; w_valid = 1'b0;
        check("race_set_wins", 64'(mxip), 64'h104);
        check("race_bvalid", 64'(b_valid), 64'd1);
        @(posedge clk); #1;
        check("race_clr_next", 64'(mxip), 64'h100);
        mxip_clr = 9'h0;
        b_ready = 1'b1;
        @(posedge clk); #1;
        b_ready = 1'b0;

        // Write beats simultaneous read; B held 5 cycles
        aw_addr = BASE + 48'h00; w_data = 64'h5555_6666_7777_8888; w_strb = 8'hFF;
        aw_valid = 1'b1; w_valid = 1'b1;
        ar_addr = BASE + 48'h00; ar_valid = 1'b1;
        #1;
        check("prio_awready", 64'(aw_ready), 64'd1);
        check("prio_arready", 64'(ar_ready), 64'd0);
        @(posedge clk); #1;
        aw_valid = 1'b0; w_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("hold_bvalid", 64'(b_valid), 64'd1);
            check("hold_bresp", 64'(b_resp), 64'(OKAY));
            check("hold_arready", 64'(ar_ready), 64'd0);
            @(posedge clk); #1;
        end
        b_ready = 1'b1;
        @(posedge clk); #1;
        b_ready = 1'b0;
        check("prio_ar_after", 64'(ar_ready), 64'd1);
        check("prio_rvalid_pre", 64'(r_valid), 64'd0);
        @(posedge clk); #1;
        ar_valid = 1'b0;
        check("prio_rvalid", 64'(r_valid), 64'd1);
        check("prio_rdata", r_data, 64'h5555_6666_7777_8888);
        r_ready = 1'b1;
        @(posedge clk); #1;
        r_ready = 1'b0;

        // Read data sampled before a same-cycle core clear
        ar_addr = BASE + 48'h18; ar_valid = 1'b1; mxip_clr = 9'h100;
        @(posedge clk); #1;
        ar_valid = 1'b0; mxip_clr = 9'h0;
        check("rdclr_data", r_data, 64'h100);
        check("rdclr_mxip", 64'(mxip), 64'h0);
        @(posedge clk); #1;
        check("rdclr_stable", r_data, 64'h100);
        r_ready = 1'b1;
        @(posedge clk); #1;
        r_ready = 1'b0;

        // Error responses, no side effects
        axi_write("set_a5", 48'h08, 64'h0A5, 8'hFF, OKAY);
        axi_write("wr_clint", 48'h18, 64'h1FF, 8'hFF, SLVERR);
        check("wr_clint_mxip", 64'(mxip), 64'h0A5);
        axi_write("wr_unmap", 48'h28, 64'h0, 8'hFF, SLVERR);
        check("wr_unmap_scr", scratch, 64'h5555_6666_7777_8888);
        axi_read("rd_lowbits", 48'h05, 64'h5555_6666_7777_8888, OKAY);
        axi_read("rd_40", 48'h40, 64'h0, SLVERR);
        axi_read("rd_20", 48'h20, 64'h0, SLVERR);
        axi_read("rd_below", 48'hFFFF_FFFF_FFF8, 64'h0, SLVERR);

        // Asynchronous reset while a read response is pending
        ar_addr = BASE + 48'h18; ar_valid = 1'b1;
        @(posedge clk); #1;
        ar_valid = 1'b0;
        check("mid_rvalid", 64'(r_valid), 64'd1);
        check("mid_rdata", r_data, 64'h0A5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rvalid", 64'(r_valid), 64'd0);
        check("arst_rdata", r_data, 64'd0);
        check("arst_mxip", 64'(mxip), 64'd0);
        check("arst_scratch", scratch, RST_SCRATCH);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        axi_read("post_scr", 48'h00, RST_SCRATCH, OKAY);
        axi_read("post_clint", 48'h18, 64'h0, OKAY);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
